// File: rtl/dpa_train_sequencer.sv
// Trains NUM_CHAN deserialized lanes one at a time: IDELAY eye sweep, centring
// on the widest stable tap run, then bitslip until the training word appears.
module dpa_train_sequencer #(
    parameter int                NUM_CHAN = 5,
    parameter int                DWIDTH   = 4,
    parameter int                TAP_BITS = 5,
    parameter logic [DWIDTH-1:0] PATTERN  = 4'b0011,
    parameter int                SETTLE   = 4,
    parameter int                SAMPLES  = 8,
    parameter int                MIN_EYE  = 4
) (
    input  logic                         clkdiv,
    input  logic                         rst,
    input  logic                         train_en,
    input  logic [NUM_CHAN*DWIDTH-1:0]   data_in,
    output logic [NUM_CHAN-1:0]          dly_ld,
    output logic [NUM_CHAN-1:0]          dly_ce,
    output logic [NUM_CHAN-1:0]          dly_inc,
    output logic [NUM_CHAN-1:0]          bitslip,
    output logic [NUM_CHAN-1:0]          chan_sel,
    output logic                         train_done,
    output logic                         train_error,
    output logic [NUM_CHAN-1:0]          chan_err,
    output logic [NUM_CHAN*TAP_BITS-1:0] tap_out
);

    localparam int RW = TAP_BITS + 1;
    localparam int SW = $clog2(SETTLE + 1);
    localparam int CW = $clog2(SAMPLES + 1);
    localparam int LW = $clog2(2*DWIDTH + 1);
    localparam logic [TAP_BITS-1:0] TAP_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_STEP, S_CENTER_LD,
        S_CENTER_INC, S_SLIP_CHK, S_SLIP, S_NEXT, S_DONE
    } state_t;

    state_t              state, next_state;
    logic [TAP_BITS-1:0] tap, run_start, best_start, target, inc_cnt;
    logic [RW-1:0]       run_len, best_len, run_next;
    logic [SW-1:0]       settle_cnt;
    logic [CW-1:0]       sample_cnt;
    logic [LW-1:0]       slip_cnt;
    logic [DWIDTH-1:0]   word, first_word;
    logic                all_equal, inc_gap, slip_phase;
    logic                settle_done, sample_last, tap_stable, eye_ok, inc_done;

    // Selected lane's word, straight from the input with no capture register.
    always_comb begin
        word = '0;
        for (int c = 0; c < NUM_CHAN; c++)
            if (chan_sel[c]) word = word | data_in[c*DWIDTH +: DWIDTH];
    end

    assign settle_done = settle_cnt == SW'(SETTLE - 1);
    assign sample_last = sample_cnt == CW'(SAMPLES - 1);
    assign tap_stable  = all_equal && (word == first_word);
    assign run_next    = run_len + 1'b1;
    assign eye_ok      = best_len >= RW'(MIN_EYE);
    assign inc_done    = !inc_gap && (inc_cnt == target);

    // NOTE: sequential state uses <= so every flop sees the pre-edge values.
    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:       if (train_en) next_state = S_LOAD;
            S_LOAD:       next_state = S_SETTLE;
            S_SETTLE:     if (settle_done) next_state = slip_phase ? S_SLIP_CHK : S_SAMPLE;
            S_SAMPLE:     if (sample_last) next_state = S_STEP;
            S_STEP:       if (tap != TAP_MAX) next_state = S_SETTLE;
                          else next_state = eye_ok ? S_CENTER_LD : S_NEXT;
            S_CENTER_LD:  next_state = S_CENTER_INC;
            S_CENTER_INC: if (inc_done) next_state = S_SETTLE;
            S_SLIP_CHK:   if (word == PATTERN || slip_cnt >= LW'(2*DWIDTH)) next_state = S_NEXT;
                          else next_state = S_SLIP;
            S_SLIP:       next_state = S_SETTLE;
            S_NEXT:       next_state = chan_sel[NUM_CHAN-1] ? S_DONE : S_LOAD;
            S_DONE:       next_state = S_DONE;
            default:      next_state = S_IDLE;
        endcase
        if (!train_en) next_state = S_IDLE;
    end

    // NOTE: every comb output gets a default first, so no path infers a latch.
    always_comb begin
        dly_ld  = '0;
        dly_ce  = '0;
        bitslip = '0;
        case (state)
            S_LOAD, S_CENTER_LD: dly_ld = chan_sel;
            S_STEP:              if (tap != TAP_MAX) dly_ce = chan_sel;
            S_CENTER_INC:        if (!inc_gap && inc_cnt != target) dly_ce = chan_sel;
            S_SLIP:              bitslip = chan_sel;
            default: ;
        endcase
    end

    assign dly_inc     = dly_ce;
    assign train_done  = (state == S_DONE) && train_en;
    assign train_error = train_done && (|chan_err);

    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) begin
            chan_sel   <= '0;  chan_err   <= '0;  tap_out    <= '0;
            tap        <= '0;  run_start  <= '0;  best_start <= '0;
            target     <= '0;  inc_cnt    <= '0;  run_len    <= '0;
            best_len   <= '0;  settle_cnt <= '0;  sample_cnt <= '0;
            slip_cnt   <= '0;  first_word <= '0;  all_equal  <= 1'b0;
            inc_gap    <= 1'b0; slip_phase <= 1'b0;
        end else if (next_state == S_IDLE) begin
            // Abort or release from DONE: results stay, sequencing counters restart.
            chan_sel   <= '0;
            settle_cnt <= '0;
            sample_cnt <= '0;
            inc_cnt    <= '0;
            inc_gap    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    chan_sel <= NUM_CHAN'(1);
                    chan_err <= '0;
                    tap_out  <= '0;
                end
                S_LOAD: begin
                    tap <= '0;  run_len <= '0;  run_start <= '0;
                    best_len <= '0;  best_start <= '0;
                    slip_cnt <= '0;  slip_phase <= 1'b0;
                end
                S_SETTLE: settle_cnt <= settle_done ? '0 : settle_cnt + 1'b1;
                S_SAMPLE: begin
                    if (sample_cnt == '0) begin
                        first_word <= word;
                        all_equal  <= 1'b1;
                    end else begin
                        all_equal  <= all_equal && (word == first_word);
                    end
                    if (sample_last) begin
                        sample_cnt <= '0;
                        if (tap_stable) begin
                            run_len <= run_next;
                            if (run_len == '0) run_start <= tap;
                            // Strict compare keeps the earliest of equal-length runs.
                            if (run_next > best_len) begin
                                best_len   <= run_next;
                                best_start <= (run_len == '0) ? tap : run_start;
                            end
                        end else begin
                            run_len <= '0;
                        end
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                S_STEP: begin
                    if (tap != TAP_MAX)  tap      <= tap + 1'b1;
                    else if (!eye_ok)    chan_err <= chan_err | chan_sel;
                    else                 target   <= best_start + TAP_BITS'(best_len >> 1);
                end
                S_CENTER_LD: begin
                    tap     <= '0;
                    inc_cnt <= '0;
                    inc_gap <= 1'b0;
                end
                S_CENTER_INC: begin
                    if (inc_done) begin
                        slip_phase <= 1'b1;
                        for (int c = 0; c < NUM_CHAN; c++)
                            if (chan_sel[c]) tap_out[c*TAP_BITS +: TAP_BITS] <= target;
                    end else if (!inc_gap) begin
                        inc_cnt <= inc_cnt + 1'b1;
                        tap     <= tap + 1'b1;
                        inc_gap <= 1'b1;
                    end else begin
                        inc_gap <= 1'b0;
                    end
                end
                S_SLIP_CHK:
                    if (word != PATTERN && slip_cnt >= LW'(2*DWIDTH))
                        chan_err <= chan_err | chan_sel;
                S_SLIP: slip_cnt <= slip_cnt + 1'b1;
                S_NEXT: chan_sel <= chan_sel << 1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dpa_train_sequencer.sv
// Bench for dpa_train_sequencer: a lane model answers IDELAY/bitslip pulses,
// a scoreboard queue holds the expected training result for each run.
module tb_dpa_train_sequencer;

    localparam int NUM_CHAN = 2;
    localparam int DWIDTH   = 4;
    localparam int TAP_BITS = 5;
    localparam int NTAP     = 1 << TAP_BITS;
    localparam int MIN_EYE  = 4;
    localparam int MAX_CYC  = 4000;
    localparam logic [DWIDTH-1:0] PATTERN = 4'b0011;

    logic                         clkdiv = 1'b0;
    logic                         rst = 1'b1;
    logic                         train_en = 1'b0;
    logic [NUM_CHAN*DWIDTH-1:0]   data_in = '0;
    logic [NUM_CHAN-1:0]          dly_ld, dly_ce, dly_inc, bitslip, chan_sel, chan_err;
    logic                         train_done, train_error;
    logic [NUM_CHAN*TAP_BITS-1:0] tap_out;

    dpa_train_sequencer #(
        .NUM_CHAN(NUM_CHAN), .DWIDTH(DWIDTH), .TAP_BITS(TAP_BITS), .PATTERN(PATTERN),
        .SETTLE(4), .SAMPLES(8), .MIN_EYE(MIN_EYE)
    ) dut (
        .clkdiv(clkdiv), .rst(rst), .train_en(train_en), .data_in(data_in),
        .dly_ld(dly_ld), .dly_ce(dly_ce), .dly_inc(dly_inc), .bitslip(bitslip),
        .chan_sel(chan_sel), .train_done(train_done), .train_error(train_error),
        .chan_err(chan_err), .tap_out(tap_out)
    );

    always #5 clkdiv = ~clkdiv;

    typedef struct packed {
        logic [NUM_CHAN-1:0][TAP_BITS-1:0] tap;
        logic [NUM_CHAN-1:0]               err;
        logic [NUM_CHAN-1:0][3:0]          slips;
        logic [NUM_CHAN-1:0][1:0]          lds;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    // Lane profile: which taps give a stable word, and how many slips align it.
    logic [NTAP-1:0] mask [NUM_CHAN];
    int              offset [NUM_CHAN];
    bit              never [NUM_CHAN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DWIDTH-1:0] rotl(input logic [DWIDTH-1:0] x, input int k);
        logic [2*DWIDTH-1:0] d;
        d = {x, x} << (k % DWIDTH);
        return d[2*DWIDTH-1:DWIDTH];
    endfunction

    // Reference: widest stable run (earliest on ties), centre it, then slip count.
    function automatic exp_t model();
        exp_t e;
        int   best_s, best_l, l;
        bit   prev;
        e = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            best_s = 0;
            best_l = 0;
            for (int s = 0; s < NTAP; s++) begin
                prev = (s > 0) ? mask[c][s-1] : 1'b0;
                if (mask[c][s] && !prev) begin
                    l = 0;
                    while (s + l < NTAP && mask[c][s+l]) l++;
                    if (l > best_l) begin best_l = l; best_s = s; end
                end
            end
            if (best_l < MIN_EYE) begin
                e.err[c] = 1'b1;
                e.lds[c] = 2'd1;
            end else begin
                e.tap[c] = TAP_BITS'(best_s + best_l / 2);
                e.lds[c] = 2'd2;
                if (never[c]) begin e.slips[c] = 4'd8; e.err[c] = 1'b1; end
                else          e.slips[c] = 4'(offset[c]);
            end
        end
        return e;
    endfunction

    task automatic set_profile(input int c, input int lo, input int hi, input int off, input bit nv);
        mask[c] = '0;
        for (int t = lo; t <= hi; t++) mask[c][t] = 1'b1;
        offset[c] = off;
        never[c]  = nv;
    endtask

    task automatic random_profile(input int c);
        int nruns, st, len;
        mask[c] = '0;
        nruns = $urandom_range(1, 2);
        for (int r = 0; r < nruns; r++) begin
            st  = $urandom_range(0, NTAP - 1);
            len = $urandom_range(1, 14);
            for (int t = st; t < st + len && t < NTAP; t++) mask[c][t] = 1'b1;
        end
        offset[c] = $urandom_range(0, 3);
        never[c]  = ($urandom_range(0, 5) == 0);
    endtask

    task automatic start_training(input exp_t e);
        sb.push_back(e);
        train_en = 1'b1;
    endtask

    task automatic finish_training(input exp_t e);
        int   n;
        exp_t dummy;
        n = 0;
        while (!train_done && n < MAX_CYC) begin
            @(negedge clkdiv);
            n++;
        end
        check("done_within_budget", 32'(train_done), 32'd1);
        if (!train_done && sb.size() > 0) dummy = sb.pop_front();
        @(negedge clkdiv);
        train_en = 1'b0;
        @(negedge clkdiv);
        @(negedge clkdiv);
        check("done_cleared", 32'(train_done), 32'd0);
        check("idle_chan_sel", 32'(chan_sel), 32'd0);
        check("tap_out_retained", 32'(tap_out), 32'(e.tap));
        check("chan_err_retained", 32'(chan_err), 32'(e.err));
    endtask

    // Lane model: reacts to the pulses of the current cycle, drives the next word.
    initial begin : link
        int                mtap [NUM_CHAN];
        int                mslip [NUM_CHAN];
        logic [DWIDTH-1:0] w [NUM_CHAN];
        for (int c = 0; c < NUM_CHAN; c++) begin
            mtap[c] = 0; mslip[c] = 0; w[c] = '0;
            mask[c] = '0; offset[c] = 0; never[c] = 1'b0;
        end
        forever begin
            @(negedge clkdiv);
            for (int c = 0; c < NUM_CHAN; c++) begin
                if (dly_ld[c]) begin
                    mtap[c]  = 0;
                    mslip[c] = 0;
                end else if (dly_ce[c] && mtap[c] < NTAP - 1) begin
                    mtap[c]++;
                end
                if (bitslip[c]) mslip[c]++;
                if (mask[c][mtap[c]])
                    w[c] = never[c] ? rotl(4'b0101, mslip[c])
                                    : rotl(PATTERN, (offset[c] - (mslip[c] % DWIDTH) + DWIDTH) % DWIDTH);
                else
                    w[c] = w[c] ^ DWIDTH'($urandom_range(1, (1 << DWIDTH) - 1));
                data_in[c*DWIDTH +: DWIDTH] = w[c];
            end
        end
    end

    // Monitor: pulse protocol every cycle, scoreboard pop whenever train_done rises.
    initial begin : monitor
        int   slips [NUM_CHAN];
        int   lds [NUM_CHAN];
        int   kinds;
        bit   done_q, proto_ok;
        exp_t e;
        done_q = 1'b0;
        for (int c = 0; c < NUM_CHAN; c++) begin slips[c] = 0; lds[c] = 0; end
        forever begin
            @(negedge clkdiv);
            kinds    = int'(|dly_ld) + int'(|dly_ce) + int'(|bitslip);
            proto_ok = (kinds <= 1) && $onehot0(chan_sel) && (dly_inc == dly_ce)
                    && (((dly_ld | dly_ce | bitslip) & ~chan_sel) == '0);
            check("pulse_protocol", 32'(proto_ok), 32'd1);
            if (rst || (chan_sel == '0 && !train_done))
                for (int c = 0; c < NUM_CHAN; c++) begin slips[c] = 0; lds[c] = 0; end
            for (int c = 0; c < NUM_CHAN; c++) begin
                if (bitslip[c]) slips[c]++;
                if (dly_ld[c])  lds[c]++;
            end
            if (train_done && !done_q) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("train_error", 32'(train_error), 32'(|e.err));
                    check("done_chan_sel", 32'(chan_sel), 32'd0);
                    for (int c = 0; c < NUM_CHAN; c++) begin
                        check($sformatf("tap_out[%0d]", c), 32'(tap_out[c*TAP_BITS +: TAP_BITS]), 32'(e.tap[c]));
                        check($sformatf("chan_err[%0d]", c), 32'(chan_err[c]), 32'(e.err[c]));
                        check($sformatf("bitslips[%0d]", c), 32'(slips[c]), 32'(e.slips[c]));
                        check($sformatf("dly_loads[%0d]", c), 32'(lds[c]), 32'(e.lds[c]));
                    end
                end
            end
            done_q = train_done;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        exp_t e41, e;
        int   n, seen;

        #12;
        check("rst_chan_sel", 32'(chan_sel), 32'd0);
        check("rst_pulses", 32'({dly_ld, dly_ce, dly_inc, bitslip}), 32'd0);
        check("rst_done_error", 32'({train_done, train_error}), 32'd0);
        check("rst_chan_err", 32'(chan_err), 32'd0);
        check("rst_tap_out", 32'(tap_out), 32'd0);
        @(negedge clkdiv);
        rst = 1'b0;
        repeat (2) @(negedge clkdiv);

        // Wide eye with two slips on ch0; too-narrow eye on ch1.
        set_profile(0, 6, 17, 2, 1'b0);
        set_profile(1, 3, 5, 0, 1'b0);
        e41 = '0;
        e41.tap[0] = 5'd12; e41.slips[0] = 4'd2; e41.lds[0] = 2'd2;
        e41.err[1] = 1'b1;  e41.lds[1]   = 2'd1;
        start_training(e41);
        finish_training(e41);

        // Two equal runs: earliest wins. ch1 centred on 10..20.
        set_profile(0, 2, 7, 1, 1'b0);
        for (int t = 20; t <= 25; t++) mask[0][t] = 1'b1;
        set_profile(1, 10, 20, 0, 1'b0);
        e = '0;
        e.tap[0] = 5'd5;  e.slips[0] = 4'd1; e.lds[0] = 2'd2;
        e.tap[1] = 5'd15; e.slips[1] = 4'd0; e.lds[1] = 2'd2;
        start_training(e);
        finish_training(e);

        // Pattern never appears on ch0; ch1 eye exactly MIN_EYE at the top taps.
        set_profile(0, 0, NTAP - 1, 0, 1'b1);
        set_profile(1, 28, 31, 3, 1'b0);
        e = '0;
        e.tap[0] = 5'd16; e.slips[0] = 4'd8; e.err[0] = 1'b1; e.lds[0] = 2'd2;
        e.tap[1] = 5'd30; e.slips[1] = 4'd3; e.lds[1] = 2'd2;
        start_training(e);
        finish_training(e);

        // Abort during the ch0 sweep, then restart from ch0.
        set_profile(0, 6, 17, 2, 1'b0);
        set_profile(1, 3, 5, 0, 1'b0);
        train_en = 1'b1;
        n = 0; seen = 0;
        while (seen < 5 && n < MAX_CYC) begin
            @(negedge clkdiv);
            n++;
            if (dly_ce[0]) seen++;
        end
        check("abort_reached_sweep", 32'(seen >= 5), 32'd1);
        train_en = 1'b0;
        @(negedge clkdiv);
        check("abort_chan_sel", 32'(chan_sel), 32'd0);
        repeat (3) begin
            check("abort_no_pulses", 32'({dly_ld, dly_ce, bitslip}), 32'd0);
            @(negedge clkdiv);
        end
        start_training(e41);
        @(negedge clkdiv);
        check("restart_dly_ld", 32'(dly_ld), 32'd1);
        finish_training(e41);

        // Reset asserted while centring ch0.
        train_en = 1'b1;
        n = 0; seen = 0;
        while (seen < 2 && n < MAX_CYC) begin
            @(negedge clkdiv);
            n++;
            if (dly_ld[0]) seen++;
        end
        check("reached_center", 32'(seen), 32'd2);
        repeat (3) @(negedge clkdiv);
        check("center_active", 32'(chan_sel), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_chan_sel", 32'(chan_sel), 32'd0);
        check("async_rst_pulses", 32'({dly_ld, dly_ce, dly_inc, bitslip}), 32'd0);
        check("async_rst_status", 32'({train_done, train_error, chan_err}), 32'd0);
        check("async_rst_tap_out", 32'(tap_out), 32'd0);
        train_en = 1'b0;
        repeat (2) @(negedge clkdiv);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clkdiv);
            check("post_rst_idle", 32'({chan_sel, dly_ld, dly_ce, bitslip}), 32'd0);
        end

        // Randomised lanes against the reference.
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NUM_CHAN; c++) random_profile(c);
            e = model();
            start_training(e);
            finish_training(e);
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
